hpm_snapshot_sequencer: RTL and testbench



---
 rtl/hpm_snapshot_sequencer.sv | 178 +++++++++++++++++
 tb/tb_hpm_snapshot_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpm_snapshot_sequencer.sv
// hpm_snapshot_sequencer
//   Schedules HPM counter snapshots for the tracer path. A write of 0 to
//   mcountinhibit (0x320) arms the sequencer; it then takes periodic
//   snapshots every `period` cycles, plus one final snapshot when
//   0xFFFFFFFF is written to the same CSR. Each snapshot captures every
//   selected counter in one cycle. It streams the captured values one per
//   beat over valid/ready, then hands off to the detector via
//   detect_en/detect_done.
//
// Ports
//   clk_h, rst_h         clock, asynchronous active-low reset
//   csr_we/add/data      CSR write port (start/stop decode)
//   period               sampling period in cycles, 0 = final snapshot only
//   cnt_mask             counters included in a snapshot (bit i = HPM[i])
//   hpm                  live counter bank
//   out_*                snapshot beat stream (valid/ready, idx, last, seq)
//   detect_en/done       detector handshake after each snapshot
//   busy                 sequencer not idle
//   overrun_cnt          periodic samples dropped while not armed (saturating)
module hpm_snapshot_sequencer #(
    parameter int PERIOD_W = 16,
    parameter int SEQ_W    = 16
) (
    input  logic                clk_h,
    input  logic                rst_h,
    input  logic                csr_we,
    input  logic [11:0]         csr_add,
    input  logic [31:0]         csr_data,
    input  logic [PERIOD_W-1:0] period,
    input  logic [31:0]         cnt_mask,
    input  logic [31:0][63:0]   hpm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [63:0]         out_data,
    output logic [4:0]          out_idx,
    output logic                out_last,
    output logic [SEQ_W-1:0]    out_seq,
    output logic                detect_en,
    input  logic                detect_done,
    output logic                busy,
    output logic [SEQ_W-1:0]    overrun_cnt
);

    typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, STREAM, WAIT_DET} state_t;

    state_t                state;
    logic [31:0]           mask_q;
    logic [PERIOD_W-1:0]   period_q;
    logic [PERIOD_W-1:0]   timer;
    logic [31:0][63:0]     shadow;
    logic                  final_q;
    logic                  stop_pend;

    logic                  start_ev, stop_ev, expire;
    logic [4:0]            lo_idx, hi_idx, nxt_idx;

    assign start_ev = csr_we && (csr_add == 12'h320) && (csr_data == 32'h0);
    assign stop_ev  = csr_we && (csr_add == 12'h320) && (csr_data == 32'hFFFF_FFFF);
    assign expire   = (period_q != '0) && (timer == period_q - PERIOD_W'(1));
    assign busy     = (state != IDLE);

    // Lowest / highest selected counter, and the next selected counter
    // above the beat currently presented (out_idx doubles as the pointer).
    always_comb begin
        lo_idx  = '0;
        hi_idx  = '0;
        nxt_idx = '0;
        for (int i = 31; i >= 0; i--)
            if (mask_q[i]) lo_idx = 5'(i);
        for (int i = 0; i < 32; i++)
            if (mask_q[i]) hi_idx = 5'(i);
        for (int i = 31; i >= 0; i--)
            if (mask_q[i] && (i > int'(out_idx))) nxt_idx = 5'(i);
    end

    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            state       <= IDLE;
            mask_q      <= '0;
            period_q    <= '0;
            timer       <= '0;
            shadow      <= '0;
            final_q     <= 1'b0;
            stop_pend   <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_idx     <= '0;
            out_last    <= 1'b0;
            out_seq     <= '0;
            detect_en   <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ev && (cnt_mask != '0)) begin
                        mask_q      <= cnt_mask;
                        period_q    <= period;
                        timer       <= '0;
                        out_seq     <= '0;
                        overrun_cnt <= '0;
                        stop_pend   <= 1'b0;
                        final_q     <= 1'b0;
                        state       <= ARMED;
                    end
                end
                ARMED: begin
                    // A stop wins over a coincident expiry: one snapshot, final.
                    if (stop_ev || stop_pend) begin
                        final_q <= 1'b1;
                        timer   <= '0;
                        state   <= CAPTURE;
                    end else if (expire) begin
                        timer   <= '0;
                        state   <= CAPTURE;
                    end else begin
                        timer   <= timer + PERIOD_W'(1);
                    end
                end
                default: begin
                    // Outside ARMED the period keeps running; an expiry here
                    // cannot be serviced, so it is counted and dropped.
                    if (expire) begin
                        timer <= '0;
                        if (overrun_cnt != '1) overrun_cnt <= overrun_cnt + SEQ_W'(1);
                    end else begin
                        timer <= timer + PERIOD_W'(1);
                    end
                    if (stop_ev) stop_pend <= 1'b1;

                    case (state)
                        CAPTURE: begin
                            // All selected counters sampled on the same edge.
                            for (int i = 0; i < 32; i++)
                                if (mask_q[i]) shadow[i] <= hpm[i];
                            out_valid <= 1'b1;
                            out_data  <= hpm[lo_idx];
                            out_idx   <= lo_idx;
                            out_last  <= (lo_idx == hi_idx);
                            state     <= STREAM;
                        end
                        STREAM: begin
                            if (out_ready) begin
                                if (out_last) begin
                                    out_valid <= 1'b0;
                                    out_last  <= 1'b0;
                                    out_seq   <= out_seq + SEQ_W'(1);
                                    detect_en <= 1'b1;
                                    state     <= WAIT_DET;
                                end else begin
                                    out_data  <= shadow[nxt_idx];
                                    out_idx   <= nxt_idx;
                                    out_last  <= (nxt_idx == hi_idx);
                                end
                            end
                        end
                        WAIT_DET: begin
                            if (detect_done) begin
                                detect_en <= 1'b0;
                                // A stop that arrived mid-snapshot leaves
                                // final_q clear, so we re-arm and ARMED takes
                                // the final snapshot straight away.
                                if (final_q) begin
                                    final_q   <= 1'b0;
                                    stop_pend <= 1'b0;
                                    state     <= IDLE;
                                end else begin
                                    state     <= ARMED;
                                end
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hpm_snapshot_sequencer.sv
module tb_hpm_snapshot_sequencer;

    logic              clk_h = 1'b0;
    logic              rst_h = 1'b0;
    logic              csr_we;
    logic [11:0]       csr_add;
    logic [31:0]       csr_data;
    logic [15:0]       period;
    logic [31:0]       cnt_mask;
    logic [31:0][63:0] hpm;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_data;
    logic [4:0]        out_idx;
    logic              out_last;
    logic [15:0]       out_seq;
    logic              detect_en;
    logic              detect_done;
    logic              busy;
    logic [15:0]       overrun_cnt;

    hpm_snapshot_sequencer #(.PERIOD_W(16), .SEQ_W(16)) dut (
        .clk_h(clk_h), .rst_h(rst_h), .csr_we(csr_we), .csr_add(csr_add),
        .csr_data(csr_data), .period(period), .cnt_mask(cnt_mask), .hpm(hpm),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .out_seq(out_seq),
        .detect_en(detect_en), .detect_done(detect_done), .busy(busy),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk_h = ~clk_h;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- input drivers (one process per signal) ----------------
    int unsigned cyc = 0;
    logic [31:0] salt = 32'h0;
    always @(negedge clk_h) begin
        cyc++;
        for (int i = 0; i < 32; i++) hpm[i] = {32'(i) ^ salt, cyc};
    end

    logic rdy_mode = 1'b0;   // 0: hold rdy_val, 1: random
    logic rdy_val  = 1'b0;
    always @(negedge clk_h)
        out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_val;

    logic rnd_det = 1'b0;
    int   det_dly = 0;
    int   det_cnt = 0;
    int   cur_dly = 0;
    always @(negedge clk_h) begin
        if (!detect_en) begin
            det_cnt     = 0;
            detect_done = rnd_det && ($urandom_range(0, 7) == 0);
            cur_dly     = rnd_det ? int'($urandom_range(0, 4)) : det_dly;
        end else begin
            detect_done = (det_cnt == cur_dly);
            det_cnt++;
        end
    end

    // ---------------- behavioural model ----------------
    // Snapshot = queue of (index, value) pairs taken on the capture edge;
    // the stream is that queue drained one entry per accepted beat.
    typedef enum int {P_IDLE, P_ARM, P_CAP, P_SEND, P_DET} ph_t;
    ph_t         ph = P_IDLE;
    int          qi[$];
    logic [63:0] qd[$];
    logic [15:0] m_seq = 0, m_ovr = 0, m_tmr = 0, m_per = 0;
    logic [31:0] m_mask = 0;
    logic        m_fin = 0, m_spend = 0;

    always @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            ph = P_IDLE; qi.delete(); qd.delete();
            m_seq = 0; m_ovr = 0; m_tmr = 0; m_per = 0; m_mask = 0;
            m_fin = 0; m_spend = 0;
        end else begin
            logic st, sp, exp_now;
            st = csr_we && csr_add == 12'h320 && csr_data == 32'h0;
            sp = csr_we && csr_add == 12'h320 && csr_data == 32'hFFFF_FFFF;
            exp_now = (m_per != 0) && (m_tmr == m_per - 16'd1);
            if (ph == P_IDLE) begin
                if (st && cnt_mask != 0) begin
                    m_mask = cnt_mask; m_per = period; m_tmr = 0;
                    m_seq = 0; m_ovr = 0; m_spend = 0; m_fin = 0; ph = P_ARM;
                end
            end else if (ph == P_ARM) begin
                if (sp || m_spend) begin m_fin = 1; m_tmr = 0; ph = P_CAP; end
                else if (exp_now) begin m_tmr = 0; ph = P_CAP; end
                else m_tmr++;
            end else begin
                if (exp_now) begin
                    m_tmr = 0;
                    if (m_ovr != 16'hFFFF) m_ovr++;
                end else m_tmr++;
                if (sp) m_spend = 1;
                if (ph == P_CAP) begin
                    for (int i = 0; i < 32; i++)
                        if (m_mask[i]) begin qi.push_back(i); qd.push_back(hpm[i]); end
                    ph = P_SEND;
                end else if (ph == P_SEND) begin
                    if (out_ready) begin
                        void'(qi.pop_front()); void'(qd.pop_front());
                        if (qi.size() == 0) begin m_seq++; ph = P_DET; end
                    end
                end else if (detect_done) begin
                    if (m_fin) begin m_fin = 0; m_spend = 0; ph = P_IDLE; end
                    else ph = P_ARM;
                end
            end
        end
    end

    // ---------------- compare + beat monitor ----------------
    int          n_pkt = 0;
    int          obs_idx[$];
    logic [63:0] obs_dat[$];

    always @(negedge clk_h) begin
        #1;
        if (rst_h) begin
            chk("out_valid", out_valid, ph == P_SEND);
            chk("detect_en", detect_en, ph == P_DET);
            chk("busy", busy, ph != P_IDLE);
            chk("out_seq", out_seq, m_seq);
            chk("overrun_cnt", overrun_cnt, m_ovr);
            if (ph == P_SEND && qi.size() > 0) begin
                chk("out_idx", out_idx, qi[0]);
                chk("out_data", out_data, qd[0]);
                chk("out_last", out_last, qi.size() == 1);
            end
            if (out_valid && out_ready) begin
                obs_idx.push_back(int'(out_idx));
                obs_dat.push_back(out_data);
                if (out_last) n_pkt++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk_h);
        csr_we = 1'b1; csr_add = a; csr_data = d;
        @(negedge clk_h);
        csr_we = 1'b0;
    endtask

    task automatic do_start(); csr_wr(12'h320, 32'h0); endtask
    task automatic do_stop();  csr_wr(12'h320, 32'hFFFF_FFFF); endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin @(negedge clk_h); k++; end
        chk("wait_idle", busy, 1'b0);
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!out_valid && k < budget) begin @(negedge clk_h); k++; end
        chk("wait_valid", out_valid, 1'b1);
    endtask

    task automatic clr_obs();
        obs_idx.delete(); obs_dat.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int basic_exp[6] = '{0, 2, 8, 9, 10, 11};

    initial begin
        int pkt0;
        logic [63:0] d0;
        logic [4:0]  i0;
        csr_we = 0; csr_add = 0; csr_data = 0; period = 0; cnt_mask = 0;

        // reset state
        repeat (3) @(negedge clk_h);
        #2;
        chk("rst_valid", out_valid, 0); chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);     chk("rst_last", out_last, 0);
        chk("rst_seq", out_seq, 0);     chk("rst_det", detect_en, 0);
        chk("rst_busy", busy, 0);       chk("rst_ovr", overrun_cnt, 0);
        @(negedge clk_h);
        rst_h = 1'b1;

        // basic final-only snapshot
        salt = $urandom(); clr_obs();
        cnt_mask = 32'h0000_0F05; period = 0; rdy_mode = 0; rdy_val = 1; det_dly = 3;
        do_start();
        repeat (10) @(negedge clk_h);
        do_stop();
        wait_idle(200);
        chk("basic_beats", obs_idx.size(), 6);
        for (int k = 0; k < 6 && k < obs_idx.size(); k++) begin
            chk("basic_idx", obs_idx[k], basic_exp[k]);
            chk("basic_hi", obs_dat[k][63:32], 32'(basic_exp[k]) ^ salt);
            chk("basic_coherent", obs_dat[k][31:0], obs_dat[0][31:0]);
        end
        chk("basic_seq", out_seq, 1);

        // periodic, period 100
        cnt_mask = 32'h1; period = 100; det_dly = 0;
        do_start();
        repeat (450) @(negedge clk_h);
        chk("periodic_seq", out_seq, 4);
        chk("periodic_ovr", overrun_cnt, 0);
        do_stop();
        wait_idle(200);
        chk("periodic_final_seq", out_seq, 5);

        // backpressure + overrun
        cnt_mask = 32'hFFF; period = 4; rdy_val = 0; det_dly = 1;
        do_start();
        wait_valid(50);
        d0 = out_data; i0 = out_idx;
        repeat (20) begin
            @(negedge clk_h); #1;
            chk("bp_data_stable", out_data, d0);
            chk("bp_idx_stable", out_idx, i0);
            chk("bp_valid_held", out_valid, 1);
        end
        chk("bp_ovr_min", overrun_cnt >= 5, 1);
        rdy_val = 1;
        repeat (40) @(negedge clk_h);
        do_stop();
        wait_idle(500);

        // stop mid-stream: current snapshot plus one final
        cnt_mask = 32'hFFFF_FFFF; period = 50; rdy_mode = 1; pkt0 = n_pkt;
        do_start();
        wait_valid(100);
        do_stop();
        wait_idle(2000);
        chk("stop_mid_pkts", n_pkt - pkt0, 2);

        // edge cases
        rdy_mode = 0; rdy_val = 1;
        cnt_mask = 0; period = 0;
        do_start();
        repeat (3) @(negedge clk_h);
        chk("mask0_idle", busy, 0);
        cnt_mask = 32'h1;
        csr_wr(12'h321, 32'h0);
        csr_wr(12'h320, 32'h5);
        repeat (2) @(negedge clk_h);
        chk("bad_write_idle", busy, 0);
        clr_obs(); cnt_mask = 32'h3;
        do_start();
        repeat (3) @(negedge clk_h);
        cnt_mask = 32'hFF;
        do_start();
        do_stop();
        wait_idle(200);
        chk("busy_start_beats", obs_idx.size(), 2);
        chk("busy_start_seq", out_seq, 1);

        // reset during STREAM
        cnt_mask = 32'hFFFF; period = 3; rdy_val = 0;
        do_start();
        wait_valid(50);
        @(negedge clk_h);
        rst_h = 1'b0;
        #2;
        chk("mid_rst_valid", out_valid, 0); chk("mid_rst_data", out_data, 0);
        chk("mid_rst_idx", out_idx, 0);     chk("mid_rst_det", detect_en, 0);
        chk("mid_rst_busy", busy, 0);       chk("mid_rst_ovr", overrun_cnt, 0);
        @(negedge clk_h);
        rst_h = 1'b1;
        clr_obs(); cnt_mask = 32'h5; period = 0; rdy_val = 1;
        do_start();
        repeat (5) @(negedge clk_h);
        do_stop();
        wait_idle(200);
        chk("post_rst_beats", obs_idx.size(), 2);
        if (obs_idx.size() == 2) chk("post_rst_idx1", obs_idx[1], 2);
        chk("post_rst_seq", out_seq, 1);

        // randomized traffic checked by the model every cycle
        rdy_mode = 1; rnd_det = 1;
        for (int run = 0; run < 8; run++) begin
            cnt_mask = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
            period   = 16'($urandom_range(0, 12));
            salt     = $urandom();
            for (int c = 0; c < 300; c++) begin
                int r;
                @(negedge clk_h);
                r = int'($urandom_range(0, 99));
                csr_we = 1'b0;
                if (r < 4) begin
                    csr_we = 1; csr_add = 12'h320; csr_data = 32'h0;
                end else if (r < 6) begin
                    csr_we = 1; csr_add = 12'h320; csr_data = 32'hFFFF_FFFF;
                end else if (r < 10) begin
                    csr_we = 1; csr_add = 12'($urandom_range(0, 4095)); csr_data = $urandom();
                end
                if (r == 50) cnt_mask = $urandom();
                if (r == 51) period = 16'($urandom_range(0, 12));
            end
            @(negedge clk_h);
            csr_we = 1'b0;
            do_stop();
            wait_idle(3000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
